gf8_reduce_acc: RTL and testbench
=================================

# gf8_reduce_acc

Pipelined GF(2^8) modular-reduction and accumulate stage that sits directly downstream of the 8x8 carry-less (Karatsuba) multiplier. It takes the 15-bit polynomial product, reduces it modulo a fixed irreducible polynomial, and XOR-accumulates the reduced results over a frame. The result is a running GF(2^8) dot product per beat. Input and output are valid/ready streams with full back-pressure.

## Interface
- `POLY`, default `9'h11B`: irreducible field polynomial. Bit 8 must be 1; elaboration fails otherwise.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  the input beat is valid.
- `in_ready`  out  1  the block can accept a beat.
- `in_prod`  in  15  carry-less product from the multiplier.
- `in_last`  in  1  this beat closes the accumulation frame.
- `out_valid`  out  1  the output beat is valid.
- `out_ready`  in  1  the consumer accepts the output beat.
- `out_data`  out  8  running accumulated sum, including this beat.
- `out_last`  out  1  this beat is the frame's last.

## Operation
- An input beat is accepted on a cycle where `in_valid && in_ready`. An output beat is consumed on a cycle where `out_valid && out_ready`.
- Reduction rule: for k = 14 down to 8, if bit k is set, XOR the working value with `POLY << (k-8)`. The 8-bit result is the product mod `POLY`.
- Stage 1 (S1) registers an 11-bit intermediate after folding bits 14..11. S1 also carries `last`.
- Stage 2 (S2) folds bits 10..8 to get 8 bits `r`. On load into S2 it performs these steps:
  - Compute `sum = acc ^ r`.
  - Register `out_data = sum`.
  - Set `acc` to 0 if `last`, else to `sum`.
- `acc` changes only when a beat loads into S2. Stalls never alter `acc` or the held output.
- The pipeline is elastic:
  - Each stage has a valid bit and advances when it is empty or being drained.
  - `in_ready = !s1_v || s2_free`, where `s2_free = !s2_v || out_ready`.
  - There are no bubbles under continuous flow.
- `out_valid` equals the S2 valid bit. `out_data` and `out_last` stay stable while `out_valid && !out_ready`.
- Frames of length 1 are legal: the output is `r` with `out_last` = 1.
- Reset mid-frame discards all in-flight beats and the partial `acc`. The first beat after reset starts a new frame.

## Timing
- Reset values:
  - `in_ready` = 1 (combinational from empty stages).
  - `out_valid` = 0, `out_data` = 0x00, `out_last` = 0.
  - S1 and S2 valid bits = 0, `acc` = 0x00.
- Latency: a beat accepted at edge N appears with `out_valid` = 1 after edge N+1, i.e. it is consumable at edge N+2 if `out_ready` is high.
- Throughput: 1 beat/cycle when `out_ready` is held high.
- With both stages full and `out_ready` = 0, `in_ready` = 0 in the same cycle (combinational path from `out_ready`).
- Simultaneous accept and drain in one cycle is allowed: S2 reloads from S1 and S1 reloads from the input. Nothing is lost or duplicated.
- No combinational path exists from `in_valid` to `out_valid` or `in_ready`.

## Structure
- Shared field package `gf8_pkg` holds:
  - `GF_POLY_AES = 9'h11B`
  - `gf8_t` (logic [7:0]) and `gfprod_t` (logic [14:0])
  - function `gf_fold(value, poly, hi, lo)` implementing the shift-XOR rule; reused by both stages.
- One natural sub-module: `gf8_pipe_reg`, a single valid/ready-gated register slice instantiated for S1 and S2. Accumulate logic stays in the top level.

## Test plan
- Single-beat frames with `POLY` = 0x11B and `out_ready` = 1:
  - `in_prod` = 0x2B79 -> `out_data` 0xC1, `out_last` 1.
  - `in_prod` = 0x3F7E -> 0x01.
  - `in_prod` = 0x4000 -> 0x9A.
  - `in_prod` = 0x00FF -> 0xFF.
- Frame accumulation: beats 0x2B79, then 0x3F7E with `last` -> outputs 0xC1 (`last` 0), then 0xC0 (`last` 1). A following single beat 0x0001 with `last` -> 0x01, showing `acc` cleared.
- Back-pressure:
  - Stream 6 beats with `out_ready` toggling 1,0,0,1,...
  - Require that no beat is dropped or duplicated, that `out_data` is stable while stalled, and that `in_ready` is 0 whenever both stages are full and `out_ready` is 0.
- Full throughput: 16 back-to-back beats (x^k products, k = 0..14, plus 0x0000) with `out_ready` = 1 -> 16 consecutive `out_valid` cycles starting 2 cycles after the first accept, with correct running XOR.
- Reset mid-frame:
  - Send 2 non-last beats, then assert `rst_n` = 0 asynchronously between edges.
  - `out_valid` drops immediately.
  - After release, 0x2B79 with `last` -> 0xC1, showing no stale `acc`.

Source files
------------

// File: rtl/gf8_pkg.sv
// Shared GF(2^8) field definitions: default AES polynomial, field and product
// types, and the shift-XOR fold used by both reduction stages.
package gf8_pkg;

    localparam logic [8:0] GF_POLY_AES = 9'h11B;

    typedef logic [7:0]  gf8_t;
    typedef logic [14:0] gfprod_t;

    // Clear product bits hi down to lo by XORing in POLY aligned under each set
    // bit, highest bit first. Bits outside [hi:lo] are left alone, so a caller
    // can split the full 14..8 reduction across pipeline stages.
    function automatic gfprod_t gf_fold(input gfprod_t value, input logic [8:0] poly,
                                        input int hi, input int lo);
        gfprod_t v;
        v = value;
        for (int k = 14; k >= 8; k--) begin
            if (k <= hi && k >= lo && v[k]) begin
                v = v ^ (gfprod_t'(poly) << (k - 8));
            end
        end
        return v;
    endfunction

endpackage

// File: rtl/gf8_pipe_reg.sv
// One elastic pipeline slice: a valid bit plus a W-bit payload register.
//
// Handshake: a beat moves across an interface on any cycle where valid and
// ready are both high. valid never depends on ready on the same side; the
// slice's up_ready_o is high when it is empty or its beat is leaving downstream
// this cycle, so it can accept and hand off in one cycle without a bubble.
module gf8_pipe_reg #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         up_valid_i,
    output logic         up_ready_o,
    input  logic [W-1:0] data_i,
    output logic         valid_o,
    input  logic         down_ready_i,
    output logic [W-1:0] data_o
);

    logic         valid_q, valid_d;
    logic [W-1:0] data_q, data_d;
    logic         load;

    assign up_ready_o = !valid_q || down_ready_i;
    assign load       = up_valid_i && up_ready_o;
    assign valid_o    = valid_q;
    assign data_o     = data_q;

    // Next state: load a new beat, otherwise empty out when drained, otherwise hold.
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (load) begin
            valid_d = 1'b1;
            data_d  = data_i;
        end else if (down_ready_i) begin
            valid_d = 1'b0;
        end
    end

    // Slice registers; payload only changes on load so stalled data stays put.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

endmodule

// File: rtl/gf8_reduce_acc.sv
// Two-stage GF(2^8) reduction of a 15-bit carry-less product followed by a
// per-frame XOR accumulator. S1 folds bits 14..11, S2 folds 10..8 and adds the
// result into the running sum, which is what each output beat carries.
module gf8_reduce_acc
    import gf8_pkg::*;
#(
    parameter logic [8:0] POLY = GF_POLY_AES
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [14:0] in_prod,
    input  logic        in_last,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [7:0]  out_data,
    output logic        out_last
);

    // A polynomial without x^8 is not degree 8, so the fold would be wrong.
    if (POLY[8] != 1'b1) begin : g_poly_check
        $error("gf8_reduce_acc: POLY bit 8 must be set");
    end

    // S1 payload: {last, 11-bit partially reduced product}
    logic [11:0] s1_din, s1_dout;
    logic        s1_v;
    logic        s2_ready;

    // S2 payload: {last, running sum}
    logic [8:0]  s2_din, s2_dout;
    logic        s2_load;

    gf8_t        r;
    gf8_t        sum;
    gf8_t        acc_q, acc_d;

    assign s1_din = {in_last, 11'(gf_fold(gfprod_t'(in_prod), POLY, 14, 11))};

    gf8_pipe_reg #(.W(12)) u_s1 (
        .clk          (clk),
        .rst_n        (rst_n),
        .up_valid_i   (in_valid),
        .up_ready_o   (in_ready),
        .data_i       (s1_din),
        .valid_o      (s1_v),
        .down_ready_i (s2_ready),
        .data_o       (s1_dout)
    );

    assign r       = 8'(gf_fold(gfprod_t'(s1_dout[10:0]), POLY, 10, 8));
    assign sum     = acc_q ^ r;
    assign s2_din  = {s1_dout[11], sum};
    assign s2_load = s1_v && s2_ready;

    gf8_pipe_reg #(.W(9)) u_s2 (
        .clk          (clk),
        .rst_n        (rst_n),
        .up_valid_i   (s1_v),
        .up_ready_o   (s2_ready),
        .data_i       (s2_din),
        .valid_o      (out_valid),
        .down_ready_i (out_ready),
        .data_o       (s2_dout)
    );

    assign out_last = s2_dout[8];
    assign out_data = s2_dout[7:0];

    // Accumulator moves only when a beat enters S2; a closing beat restarts the frame.
    always_comb begin
        acc_d = acc_q;
        if (s2_load) begin
            acc_d = s1_dout[11] ? 8'h00 : sum;
        end
    end

    // Accumulator register; reset drops any partial frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= 8'h00;
        end else begin
            acc_q <= acc_d;
        end
    end

endmodule

// File: tb/tb_gf8_reduce_acc.sv
module tb_gf8_reduce_acc;

  localparam logic [8:0] POLY = 9'h11B;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [14:0] in_prod = '0;
  logic        in_last = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [7:0]  out_data;
  logic        out_last;

  always #5 clk = ~clk;

  gf8_reduce_acc #(.POLY(POLY)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_prod   (in_prod),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last)
  );

  int         n_cmp = 0;
  int         n_err = 0;
  int         cyc = 0;
  int         n_out = 0;
  logic [8:0] exp_q[$];
  int         age_q[$];
  logic [7:0] m_acc = 8'h00;
  logic       hold_v = 1'b0;
  logic [8:0] hold_val = '0;

  // Reference: long division by POLY using magnitude compares on plain ints.
  function automatic logic [7:0] ref_mod(input logic [14:0] p);
    int v;
    v = int'(p);
    for (int m = 14; m >= 8; m--) begin
      if (v >= (1 << m)) v = v ^ (int'(POLY) << (m - 8));
    end
    return v[7:0];
  endfunction

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive just after a negedge, sample 1ns later, score, then
  // advance past the posedge and the following negedge.
  task automatic step(input logic v, input logic [14:0] p, input logic l,
                      input logic rdy, output logic accepted);
    logic [8:0] e;
    logic [7:0] s;
    in_valid  = v;
    in_prod   = p;
    in_last   = l;
    out_ready = rdy;
    #1;
    check("in_ready", 16'(in_ready), 16'(!(exp_q.size() == 2 && !rdy)));
    check("out_valid", 16'(out_valid),
          16'(exp_q.size() >= 2 || (exp_q.size() == 1 && age_q[0] + 2 <= cyc)));
    if (hold_v) begin
      check("hold_data", 16'({out_last, out_data}), 16'(hold_val));
    end
    if (out_valid && rdy && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      void'(age_q.pop_front());
      check("out_beat", 16'({out_last, out_data}), 16'(e));
      n_out++;
    end
    hold_v   = out_valid && !rdy;
    hold_val = {out_last, out_data};
    accepted = v && in_ready;
    if (accepted) begin
      s = m_acc ^ ref_mod(p);
      exp_q.push_back({l, s});
      age_q.push_back(cyc);
      m_acc = l ? 8'h00 : s;
    end
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  task automatic flush();
    logic a;
    for (int i = 0; i < 12 && exp_q.size() > 0; i++) begin
      step(1'b0, 15'(16'($urandom_range(0, 32767))), 1'b0, 1'b1, a);
    end
    check("flush_empty", 16'(exp_q.size()), 16'd0);
  endtask

  // Present one beat, holding it until accepted, with a bounded wait.
  task automatic send(input logic [14:0] p, input logic l, input logic rdy);
    logic a;
    int   tries;
    a = 1'b0;
    tries = 0;
    while (!a && tries < 20) begin
      step(1'b1, p, l, rdy, a);
      tries++;
    end
    check("send_accepted", 16'(a), 16'd1);
  endtask

  initial begin
    logic a;
    int   sent;
    int   k;
    logic [14:0] p;

    // Reset state
    #12;
    check("rst_out_valid", 16'(out_valid), 16'd0);
    check("rst_out_data", 16'(out_data), 16'h00);
    check("rst_out_last", 16'(out_last), 16'd0);
    check("rst_in_ready", 16'(in_ready), 16'd1);
    @(negedge clk);
    rst_n = 1'b1;

    // Single-beat frames
    send(15'h2B79, 1'b1, 1'b1);
    send(15'h3F7E, 1'b1, 1'b1);
    send(15'h4000, 1'b1, 1'b1);
    send(15'h00FF, 1'b1, 1'b1);
    flush();

    // Two-beat frame then a single beat to show the accumulator cleared
    send(15'h2B79, 1'b0, 1'b1);
    send(15'h3F7E, 1'b1, 1'b1);
    send(15'h0001, 1'b1, 1'b1);
    flush();

    // Back-pressure: out_ready pattern 1,0,0,1 repeating
    sent = 0;
    k = 0;
    p = 15'(16'($urandom_range(0, 32767)));
    while (sent < 6 && k < 60) begin
      step(1'b1, p, (sent == 5), (k % 4 == 0 || k % 4 == 3), a);
      if (a) begin
        sent++;
        p = 15'(16'($urandom_range(0, 32767)));
      end
      k++;
    end
    check("bp_sent", 16'(sent), 16'd6);
    while (exp_q.size() > 0 && k < 80) begin
      step(1'b0, 15'h0, 1'b0, (k % 4 == 0 || k % 4 == 3), a);
      k++;
    end
    check("bp_drained", 16'(exp_q.size()), 16'd0);

    // Full throughput: x^0..x^14 then zero, out_ready held high
    n_out = 0;
    for (int i = 0; i < 16; i++) begin
      p = (i < 15) ? 15'(1 << i) : 15'h0000;
      step(1'b1, p, (i == 15), 1'b1, a);
    end
    flush();
    check("tput_beats", 16'(n_out), 16'd16);

    // Randomized traffic with random frame ends and random stalls
    sent = 0;
    k = 0;
    while (sent < 40 && k < 400) begin
      p = 15'(16'($urandom_range(0, 32767)));
      step(($urandom_range(0, 3) != 0), p, ($urandom_range(0, 3) == 0),
           ($urandom_range(0, 2) != 0), a);
      if (a) sent++;
      k++;
    end
    check("rand_sent", 16'(sent), 16'd40);
    flush();

    // Reset in the middle of a frame with both stages occupied
    step(1'b1, 15'(16'($urandom_range(0, 32767))), 1'b0, 1'b0, a);
    step(1'b1, 15'(16'($urandom_range(0, 32767))), 1'b0, 1'b0, a);
    step(1'b0, 15'h0, 1'b0, 1'b0, a);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", 16'(out_valid), 16'd0);
    check("midrst_in_ready", 16'(in_ready), 16'd1);
    check("midrst_out_data", 16'(out_data), 16'h00);
    exp_q.delete();
    age_q.delete();
    m_acc  = 8'h00;
    hold_v = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    n_out = 0;
    send(15'h2B79, 1'b1, 1'b1);
    flush();
    check("post_rst_beats", 16'(n_out), 16'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
